ahb3lite_sram_slave: RTL and testbench

- AHB3-Lite responder with a word-organised on-chip SRAM.
- Serves as the target for the DMA master ports (mXH*) in block-level and system benches; can also be instantiated as a scratch buffer on the AHB fabric.
- Supports pipelined address/data phases, programmable wait states, byte/halfword/word writes, and a two-cycle ERROR response for illegal accesses.

---
 rtl/ahb3lite_sram_slave.sv | 145 ++++++++++++++
 tb/tb_ahb3lite_sram_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite responder backed by a word-organised SRAM, with programmable
// wait states, byte/halfword/word write lanes and a two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter int MEM_DEPTH     = 1024,
  parameter int WAIT_STATES   = 0,
  parameter bit ERR_UNALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        sHSEL,
  input  logic [31:0] sHADDR,
  input  logic [31:0] sHWDATA,
  output logic [31:0] sHRDATA,
  input  logic        sHWRITE,
  input  logic [2:0]  sHSIZE,
  input  logic [2:0]  sHBURST,
  input  logic [3:0]  sHPROT,
  input  logic [1:0]  sHTRANS,
  output logic        sHREADYOUT,
  input  logic        sHREADY,
  output logic        sHRESP
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lsb_q, lsb_d;
  logic [2:0]       size_q, size_d;
  logic             write_q, write_d;
  logic             readyout_q, readyout_d;
  logic             resp_q, resp_d;

  logic [31:0] mem [MEM_DEPTH];

  logic        accept;
  logic        unaligned;
  logic        addr_err;
  logic [31:0] word_idx;
  logic [3:0]  lane_en;
  logic        unused_inputs;

  // Burst type and protection carry no meaning for a plain SRAM target.
  assign unused_inputs = ^{sHBURST, sHPROT, sHTRANS[0]};

  assign word_idx  = {2'b00, sHADDR[31:2]};
  assign accept    = sHSEL & sHREADY & sHTRANS[1] & readyout_q;
  assign unaligned = ERR_UNALIGNED &&
                     (((sHSIZE == 3'd1) && sHADDR[0]) ||
                      ((sHSIZE == 3'd2) && (sHADDR[1:0] != 2'b00)));
  assign addr_err  = (word_idx >= 32'(MEM_DEPTH)) || (sHSIZE > 3'd2) || unaligned;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lsb_d   = lsb_q;
    size_d  = size_q;
    write_d = write_q;
    if (accept) begin
      idx_d   = IDX_W'(word_idx);
      lsb_d   = sHADDR[1:0];
      size_d  = sHSIZE;
      write_d = sHWRITE;
      if (addr_err) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES == 0) begin
        state_d = ST_DATA;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_STATES - 1);
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_d = ST_DATA;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_ERR1: state_d = ST_ERR2;
        default: state_d = ST_IDLE;
      endcase
    end
    // Outputs are registered from the next state so they are glitch-free.
    readyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    resp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      lsb_q      <= 2'b00;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
      readyout_q <= 1'b1;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lsb_q      <= lsb_d;
      size_q     <= size_d;
      write_q    <= write_d;
      readyout_q <= readyout_d;
      resp_q     <= resp_d;
    end
  end

  // Errored accesses never reach DATA, so only legal sizes land here.
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      3'd0:    lane_en[lsb_q] = 1'b1;
      3'd1:    lane_en = lsb_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // NOTE: the array has no reset; SRAM contents survive rst_n_i by design.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx_q][8*i +: 8] <= sHWDATA[8*i +: 8];
      end
    end
  end

  // The write lands on the DATA edge, so a following read sees it directly.
  assign sHRDATA    = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : 32'h0;
  assign sHREADYOUT = readyout_q;
  assign sHRESP     = resp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Self-checking bench: two responders (zero-wait/strict alignment and
// three-wait/align-down) driven by directed and random AHB traffic.
module tb_ahb3lite_sram_slave;

  localparam int DEPTH0 = 1024;
  localparam int WS0    = 0;
  localparam bit EU0    = 1'b1;
  localparam int DEPTH1 = 256;
  localparam int WS1    = 3;
  localparam bit EU1    = 1'b0;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [3:0]  hprot     [2];
  logic [1:0]  htrans    [2];
  logic        hreadyout [2];
  logic        hready    [2];
  logic        hresp     [2];

  // Each responder is alone on its bus, so the bus ready is its own.
  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH0), .WAIT_STATES(WS0), .ERR_UNALIGNED(EU0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .sHSEL(hsel[0]), .sHADDR(haddr[0]),
    .sHWDATA(hwdata[0]), .sHRDATA(hrdata[0]), .sHWRITE(hwrite[0]),
    .sHSIZE(hsize[0]), .sHBURST(hburst[0]), .sHPROT(hprot[0]),
    .sHTRANS(htrans[0]), .sHREADYOUT(hreadyout[0]), .sHREADY(hready[0]),
    .sHRESP(hresp[0])
  );

  ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH1), .WAIT_STATES(WS1), .ERR_UNALIGNED(EU1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .sHSEL(hsel[1]), .sHADDR(haddr[1]),
    .sHWDATA(hwdata[1]), .sHRDATA(hrdata[1]), .sHWRITE(hwrite[1]),
    .sHSIZE(hsize[1]), .sHBURST(hburst[1]), .sHPROT(hprot[1]),
    .sHTRANS(htrans[1]), .sHREADYOUT(hreadyout[1]), .sHREADY(hready[1]),
    .sHRESP(hresp[1])
  );

  // Byte-addressed reference memory per responder.
  bit [7:0] mb [2][4096];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic bit eu_of(input int d);
    return (d == 0) ? EU0 : EU1;
  endfunction

  function automatic txn_t mk(input logic write, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] trans = 2'b10);
    txn_t t;
    t.sel = 1'b1; t.trans = trans; t.write = write;
    t.size = size; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t mk_idle(input logic sel);
    txn_t t;
    t.sel = sel; t.trans = 2'b00; t.write = 1'b0;
    t.size = 3'd0; t.addr = 32'h0; t.wdata = 32'h0;
    return t;
  endfunction

  function automatic bit is_active(input txn_t t);
    return t.sel && t.trans[1];
  endfunction

  function automatic bit is_err(input int d, input txn_t t);
    if ((t.addr >> 2) >= 32'(depth_of(d))) return 1'b1;
    if (t.size > 3'd2) return 1'b1;
    if (eu_of(d)) begin
      if (t.size == 3'd1 && t.addr[0]) return 1'b1;
      if (t.size == 3'd2 && t.addr[1:0] != 2'b00) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    int base;
    base = int'(a) & ~3;
    return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
  endfunction

  // A 2^size-byte write covers the naturally aligned block holding the address;
  // each byte takes its data from the lane matching its position in the word.
  task automatic model_write(input int d, input txn_t t);
    int nbytes;
    int start;
    int ba;
    nbytes = 1 << t.size;
    start  = int'(t.addr) & ~(nbytes - 1);
    for (int k = 0; k < nbytes; k++) begin
      ba = start + k;
      mb[d][ba] = t.wdata[8*(ba % 4) +: 8];
    end
  endtask

  task automatic drive_addr(input int d, input txn_t t);
    hsel[d]   = t.sel;
    htrans[d] = t.trans;
    hwrite[d] = t.write;
    hsize[d]  = t.size;
    haddr[d]  = t.addr;
    hburst[d] = 3'($urandom);
    hprot[d]  = 4'($urandom);
  endtask

  // Runs a pipelined sequence; call just after a rising edge with the bus idle.
  // The expected timing of every data phase comes from the model, not the DUT.
  task automatic do_txns(input int d, input txn_t list[$]);
    int   i;
    int   p;
    bit   have_cur;
    bit   exp_ready;
    bit   exp_resp;
    bit   chk_rdata;
    logic [31:0] exp_rdata;
    txn_t cur;
    i = 0; p = 0; have_cur = 1'b0;
    cur = mk_idle(1'b0);
    while (i < list.size() || have_cur) begin
      if (i < list.size()) drive_addr(d, list[i]);
      else                 drive_addr(d, mk_idle(1'b0));
      hwdata[d] = have_cur ? cur.wdata : 32'h0;
      exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = 32'h0; chk_rdata = 1'b1;
      if (have_cur) begin
        if (is_err(d, cur)) begin
          exp_resp  = 1'b1;
          exp_ready = (p == 1);
        end else begin
          exp_ready = (p == ws_of(d));
          if (exp_ready) begin
            if (cur.write) chk_rdata = 1'b0;
            else           exp_rdata = model_read(d, cur.addr);
          end
        end
      end
      @(negedge clk);
      check($sformatf("d%0d hreadyout @%h", d, cur.addr), 32'(hreadyout[d]), 32'(exp_ready));
      check($sformatf("d%0d hresp @%h", d, cur.addr), 32'(hresp[d]), 32'(exp_resp));
      if (chk_rdata) check($sformatf("d%0d hrdata @%h", d, cur.addr), hrdata[d], exp_rdata);
      @(posedge clk);
      #1;
      if (exp_ready) begin
        if (have_cur && cur.write && !is_err(d, cur)) model_write(d, cur);
        have_cur = 1'b0;
        if (i < list.size()) begin
          cur      = list[i];
          have_cur = is_active(cur);
          i++;
        end
        p = 0;
      end else begin
        p++;
      end
    end
    drive_addr(d, mk_idle(1'b0));
    hwdata[d] = 32'h0;
  endtask

  function automatic txn_t rand_txn(input int d);
    txn_t t;
    t.sel   = ($urandom_range(0, 15) != 0);
    t.trans = ($urandom_range(0, 7) < 2) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    t.write = 1'($urandom_range(0, 1));
    t.size  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    t.addr  = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 15) == 0) t.addr = 32'(depth_of(d) * 4) + 32'($urandom_range(0, 255));
    t.wdata = $urandom;
    return t;
  endfunction

  txn_t q[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive_addr(d, mk_idle(1'b0));
      hwdata[d] = 32'h0;
    end

    // Reset values while reset is held.
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset hreadyout", d), 32'(hreadyout[d]), 32'h1);
      check($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'h0);
      check($sformatf("d%0d reset hrdata", d), hrdata[d], 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known contents in the first 16 words of both memories.
    for (int d = 0; d < 2; d++) begin
      q.delete();
      for (int w = 0; w < 16; w++) q.push_back(mk(1'b1, 3'd2, 32'(w * 4), $urandom));
      do_txns(d, q);
    end

    // Zero-wait word write then read of the same word, back to back.
    q.delete();
    q.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    do_txns(0, q);

    // Byte writes over an existing word; lanes other than the addressed one carry junk.
    q.delete();
    q.push_back(mk(1'b1, 3'd2, 32'h20, 32'hAABBCCDD));
    q.push_back(mk(1'b1, 3'd0, 32'h21, 32'h5A5A115A));
    q.push_back(mk(1'b1, 3'd0, 32'h23, 32'h225A5A5A));
    q.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
    do_txns(0, q);
    check("byte merge model", model_read(0, 32'h20), 32'h22BB11DD);

    // Unaligned, oversize and out-of-range accesses error out and write nothing.
    q.delete();
    q.push_back(mk(1'b1, 3'd2, 32'h0, 32'h01234567));
    q.push_back(mk(1'b0, 3'd2, 32'h2, 32'h0));
    q.push_back(mk(1'b1, 3'd1, 32'h1, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, 3'd3, 32'h0, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, 3'd2, 32'(4 * DEPTH0), 32'hFFFFFFFF));
    q.push_back(mk(1'b0, 3'd2, 32'h0, 32'h0));
    do_txns(0, q);
    check("errored writes left 0x0", model_read(0, 32'h0), 32'h01234567);

    // Three wait states, NONSEQ then SEQ reads; the second address is held meanwhile.
    q.delete();
    q.push_back(mk(1'b0, 3'd2, 32'h0, 32'h0, 2'b10));
    q.push_back(mk(1'b0, 3'd2, 32'h4, 32'h0, 2'b11));
    do_txns(1, q);

    // Reset during the wait states of a write: no write, outputs back to reset values.
    q.delete();
    q.push_back(mk(1'b1, 3'd2, 32'h40, 32'hCAFEF00D));
    do_txns(1, q);
    drive_addr(1, mk(1'b1, 3'd2, 32'h40, 32'h0));
    @(posedge clk);
    #1;
    drive_addr(1, mk_idle(1'b0));
    hwdata[1] = 32'h12345678;
    @(negedge clk);
    check("d1 wait before reset", 32'(hreadyout[1]), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("d1 hreadyout in reset", 32'(hreadyout[1]), 32'h1);
    check("d1 hresp in reset", 32'(hresp[1]), 32'h0);
    check("d1 hrdata in reset", hrdata[1], 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hwdata[1] = 32'h0;
    @(posedge clk);
    #1;
    q.delete();
    q.push_back(mk_idle(1'b1));
    q.push_back(mk(1'b0, 3'd2, 32'h40, 32'h0));
    do_txns(1, q);

    // Random traffic on both responders.
    for (int d = 0; d < 2; d++) begin
      q.delete();
      for (int n = 0; n < 200; n++) q.push_back(rand_txn(d));
      do_txns(d, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
